// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR MAC scheduler.
package fir_pkg;

  localparam int unsigned DW_DEF   = 16;
  localparam int unsigned CW_DEF   = 16;
  localparam int unsigned NTAP_DEF = 4;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  // Accumulator width that can never overflow: full product plus one bit per tap doubling.
  function automatic int unsigned out_width(int unsigned dw, int unsigned cw, int unsigned ntap);
    return dw + cw + $clog2(ntap);
  endfunction

  function automatic int default_coef(int unsigned k);
    return int'(k) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester strictly after last_grant, wrapping around.
module rr_arbiter #(
  parameter int unsigned NCH = 2,
  localparam int unsigned CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] last_grant,
  output logic [NCH-1:0] grant,
  output logic [CHW-1:0] grant_idx,
  output logic           grant_any
);

  int unsigned cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    // Offset 1..NCH so last_grant itself is searched last.
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = (32'(last_grant) + i) % NCH;
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = CHW'(cand);
      end
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Shares one signed MAC between NCH channels, each with its own NTAP delay line.
module fir_mac_scheduler
  import fir_pkg::*;
#(
  parameter int unsigned NCH  = 2,
  parameter int unsigned NTAP = NTAP_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned CW   = CW_DEF,
  localparam int unsigned OW  = out_width(DW, CW, NTAP),
  localparam int unsigned CHW = $clog2(NCH),
  localparam int unsigned TW  = $clog2(NTAP)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*DW-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHW-1:0]       out_ch,
  output logic signed [OW-1:0] out_data,
  input  logic                 coef_we,
  input  logic [TW:0]          coef_addr,
  input  logic signed [CW-1:0] coef_wdata,
  output logic                 coef_err,
  output logic                 busy
);

  state_t state_q, state_d;

  logic signed [DW-1:0]    dl_q [NCH][NTAP];
  logic signed [CW-1:0]    coef_q [NTAP];
  logic signed [OW-1:0]    acc_q;
  logic [TW-1:0]           tap_q;
  logic [CHW-1:0]          cur_ch_q;
  logic [CHW-1:0]          last_grant_q;
  logic                    coef_err_q;

  logic [NCH-1:0]          grant;
  logic [CHW-1:0]          grant_idx;
  logic                    grant_any;
  logic                    accept;
  logic                    addr_ok;
  logic signed [DW-1:0]    sample;
  logic signed [DW+CW-1:0] prod;

  rr_arbiter #(
    .NCH(NCH)
  ) u_arb (
    .req       (in_valid),
    .last_grant(last_grant_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign sample  = in_data[32'(grant_idx)*DW +: DW];
  assign addr_ok = coef_addr < (TW+1)'(NTAP);
  assign prod    = (DW+CW)'(coef_q[tap_q]) * (DW+CW)'(dl_q[cur_ch_q][tap_q]);

  always_comb begin
    state_d  = state_q;
    in_ready = '0;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A coefficient write owns the cycle; no sample is accepted alongside it.
        if (!coef_we && grant_any) begin
          in_ready = grant;
          accept   = 1'b1;
          state_d  = MAC;
        end
      end
      MAC:     if (tap_q == TW'(NTAP - 1)) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      tap_q        <= '0;
      cur_ch_q     <= '0;
      last_grant_q <= CHW'(NCH - 1);
      coef_err_q   <= 1'b0;
      for (int unsigned k = 0; k < NTAP; k++) coef_q[k] <= CW'(default_coef(k));
      for (int unsigned c = 0; c < NCH; c++) begin
        for (int unsigned k = 0; k < NTAP; k++) dl_q[c][k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      coef_err_q <= coef_we && ((state_q != IDLE) || !addr_ok);
      if (coef_we && (state_q == IDLE) && addr_ok) coef_q[coef_addr[TW-1:0]] <= coef_wdata;
      if (accept) begin
        for (int unsigned k = NTAP - 1; k > 0; k--) dl_q[grant_idx][k] <= dl_q[grant_idx][k-1];
        dl_q[grant_idx][0] <= sample;
        acc_q              <= '0;
        tap_q              <= '0;
        cur_ch_q           <= grant_idx;
      end
      if (state_q == MAC) begin
        acc_q <= acc_q + OW'(prod);
        tap_q <= tap_q + TW'(1);
      end
      if ((state_q == OUT) && out_ready) last_grant_q <= cur_ch_q;
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_data  = acc_q;
  assign out_ch    = cur_ch_q;
  assign coef_err  = coef_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Scoreboard bench: reference FIR/round-robin model predicts results, a monitor checks them.
module tb_fir_mac_scheduler;

  localparam int NCH  = 2;
  localparam int NTAP = 4;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int OW   = DW + CW + $clog2(NTAP);
  localparam int CHW  = $clog2(NCH);
  localparam int TW   = $clog2(NTAP);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [NCH*DW-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [CHW-1:0]       out_ch;
  logic signed [OW-1:0] out_data;
  logic                 coef_we;
  logic [TW:0]          coef_addr;
  logic signed [CW-1:0] coef_wdata;
  logic                 coef_err;
  logic                 busy;

  fir_mac_scheduler #(
    .NCH (NCH),
    .NTAP(NTAP),
    .DW  (DW),
    .CW  (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_wdata(coef_wdata),
    .coef_err  (coef_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     ch;
    longint data;
    longint edge_cyc;
  } exp_t;

  exp_t   exp_q[$];
  longint dl_m[NCH][NTAP];
  longint coef_m[NTAP];
  int     last_m;
  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  bit     rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) for (int k = 0; k < NTAP; k++) dl_m[c][k] = 0;
    for (int k = 0; k < NTAP; k++) coef_m[k] = k + 1;
    last_m = NCH - 1;
  endtask

  function automatic int pick(logic [NCH-1:0] v, int last);
    for (int i = 1; i <= NCH; i++) begin
      int c;
      c = (last + i) % NCH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic longint fir_sum(int ch);
    longint s = 0;
    for (int k = 0; k < NTAP; k++) s += coef_m[k] * dl_m[ch][k];
    return s;
  endfunction

  logic                 prev_valid, prev_ready;
  logic [CHW-1:0]       prev_ch;
  logic signed [OW-1:0] prev_data;

  always @(negedge clk) begin
    exp_t e;
    int   g;
    logic signed [DW-1:0] s;
    if (reset) begin
      prev_valid <= 1'b0;
    end else begin
      if (exp_q.size() != 0) check("in_ready_while_busy", in_ready, 0);
      if (out_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) check("unexpected_result", 0, 1);
          else check("latency", cyc, exp_q[0].edge_cyc + NTAP);
        end else if (!prev_ready) begin
          check("hold_data", out_data, prev_data);
          check("hold_ch", out_ch, prev_ch);
        end
        if (out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_ch", out_ch, e.ch);
          check("out_data", out_data, e.data);
        end
      end else if (prev_valid && !prev_ready) begin
        check("hold_valid", out_valid, 1);
      end
      if (in_ready != 0) begin
        g = pick(in_valid, last_m);
        check("grant", in_ready, (g >= 0) ? (1 << g) : 0);
        if (g >= 0 && in_ready[g]) begin
          for (int k = NTAP - 1; k > 0; k--) dl_m[g][k] = dl_m[g][k-1];
          s = in_data[g*DW +: DW];
          dl_m[g][0] = s;
          last_m = g;
          e.ch = g;
          e.data = fir_sum(g);
          e.edge_cyc = cyc + 1;
          exp_q.push_back(e);
        end
      end
      prev_valid <= out_valid;
      prev_ready <= out_ready;
      prev_ch    <= out_ch;
      prev_data  <= out_data;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(int ch, logic signed [DW-1:0] s);
    bit ok = 0;
    in_data[ch*DW +: DW] = s;
    in_valid[ch] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready[ch]) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid[ch] = 1'b0;
    check("sample_accepted", ok, 1);
  endtask

  task automatic write_coef(int addr, longint val, bit exp_err);
    @(posedge clk);
    #1;
    coef_we    = 1'b1;
    coef_addr  = addr[TW:0];
    coef_wdata = val[CW-1:0];
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    check("coef_err", coef_err, exp_err);
    if (!exp_err) coef_m[addr] = val;
    @(posedge clk);
    #1;
    check("coef_err_pulse", coef_err, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r, a;
    in_valid = '0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_coef_err", coef_err, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Impulse on ch0 with default coefficients.
    send(0, 1); send(0, 0); send(0, 0); send(0, 0);
    drain();

    // Both channels continuously valid.
    fork
      begin repeat (4) send(0, 100); end
      begin repeat (4) send(1, -100); end
    join
    drain();

    // Backpressure while a second channel is waiting.
    out_ready = 1'b0;
    fork
      send(0, 5);
      send(1, 7);
      begin
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        check("bp_result_seen", out_valid, 1);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Coefficient writes: idle write, write while busy, out-of-range address.
    write_coef(0, -2, 0);
    send(1, 1);
    drain();
    send(0, 3);
    write_coef(1, 77, 1);
    drain();
    write_coef(5, 99, 1);
    send(1, -4);
    drain();

    // Full-scale extremes.
    for (int k = 0; k < NTAP; k++) write_coef(k, 32767, 0);
    repeat (4) send(0, -32768);
    drain();

    // Randomized traffic with random backpressure.
    rand_ready = 1;
    repeat (40) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        send($urandom_range(0, NCH - 1), DW'($urandom));
      end else if (r < 8) begin
        fork
          send(0, DW'($urandom));
          send(1, DW'($urandom));
        join
      end else if (r == 8) begin
        send($urandom_range(0, NCH - 1), DW'($urandom));
        write_coef($urandom_range(0, 2 * NTAP - 1), longint'($signed(CW'($urandom))), 1);
      end else begin
        drain();
        a = $urandom_range(0, 2 * NTAP - 1);
        write_coef(a, longint'($signed(CW'($urandom))), a >= NTAP);
      end
    end
    rand_ready = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    // Reset in the middle of MAC.
    send(0, 9);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_ch", out_ch, 0);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    send(0, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
